// File: rtl/load_store_unit_32.sv
// MEM-stage load/store initiator: one request per valid/ready handshake, holds memory strobes for MEM_LATENCY cycles.
// Optional macro LSU_ALIGN_CHECK_EN turns misaligned requests into faulted responses.
module load_store_unit_32 #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic                  stall,
    output logic                  mem_enable,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam int CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MEM_LATENCY - 1);

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   count_reg, count_next;
    logic                   write_reg, write_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]  wdata_reg, wdata_next;
    logic [DATA_WIDTH-1:0]  rdata_reg, rdata_next;
    logic                   misaligned;

`ifdef LSU_ALIGN_CHECK_EN
    logic fault_reg;

    assign misaligned = (req_addr[1:0] != 2'b00);

    // Fault flag is latched at accept and only exposed while the response is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_reg <= 1'b0;
        end else if (state_reg == IDLE && req_valid) begin
            fault_reg <= misaligned;
        end
    end

    assign resp_fault = (state_reg == DONE) && fault_reg;
`else
    assign misaligned = 1'b0;
    assign resp_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            write_reg <= write_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        write_next = write_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    write_next = req_write;
                    addr_next  = req_addr >> 2;
                    wdata_next = req_wdata;
                    count_next = CNT_LOAD;
                    if (misaligned) begin
                        rdata_next = '0;
                        state_next = DONE;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (count_reg == '0) begin
                    rdata_next = write_reg ? '0 : mem_read_data;
                    state_next = DONE;
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register, so they cannot glitch in IDLE or DONE.
    assign req_ready      = (state_reg == IDLE) && !reset;
    assign stall          = (state_reg != IDLE);
    assign resp_valid     = (state_reg == DONE);
    assign resp_rdata     = rdata_reg;
    assign mem_enable     = (state_reg == ACCESS);
    assign mem_read       = (state_reg == ACCESS) && !write_reg;
    assign mem_write      = (state_reg == ACCESS) && write_reg;
    assign mem_addr       = addr_reg;
    assign mem_write_data = wdata_reg;

endmodule

// File: tb/tb_load_store_unit_32.sv
// Bench for load_store_unit_32: two instances (latency 1 and 3), directed table, hand sequences, random vs reference model.
module tb_load_store_unit_32;

    localparam int N = 2;
`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_init;
    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_write [N];
    logic [31:0] req_addr [N];
    logic [31:0] req_wdata [N];
    logic        resp_valid [N];
    logic [31:0] resp_rdata [N];
    logic        resp_fault [N];
    logic        stall [N];
    logic        mem_enable [N];
    logic        mem_read [N];
    logic        mem_write [N];
    logic [31:0] mem_addr [N];
    logic [31:0] mem_write_data [N];
    logic [31:0] mem_read_data [N];

    logic [31:0] dmem [N][64];
    logic [31:0] ref_mem [N][64];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        load_store_unit_32 #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_LATENCY(gi == 0 ? 1 : 3)
        ) dut (
            .clk           (clk),
            .reset         (reset),
            .req_valid     (req_valid[gi]),
            .req_ready     (req_ready[gi]),
            .req_write     (req_write[gi]),
            .req_addr      (req_addr[gi]),
            .req_wdata     (req_wdata[gi]),
            .resp_valid    (resp_valid[gi]),
            .resp_rdata    (resp_rdata[gi]),
            .resp_fault    (resp_fault[gi]),
            .stall         (stall[gi]),
            .mem_enable    (mem_enable[gi]),
            .mem_read      (mem_read[gi]),
            .mem_write     (mem_write[gi]),
            .mem_addr      (mem_addr[gi]),
            .mem_write_data(mem_write_data[gi]),
            .mem_read_data (mem_read_data[gi])
        );
        assign mem_read_data[gi] = (mem_enable[gi] && mem_read[gi]) ?
                                   dmem[gi][mem_addr[gi][5:0]] : 32'hBAD0_BAD0;
    end

    // Simple level-sensitive memory: writes land on every clock edge while strobed.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mem_init) begin
                for (int i = 0; i < 64; i++) dmem[k][i] <= init_word(i);
            end else if (mem_enable[k] && mem_write[k]) begin
                dmem[k][mem_addr[k][5:0]] <= mem_write_data[k];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Transaction-level reference: word memory plus the alignment rule.
    task automatic model(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic flt);
        int idx;
        idx = int'(a / 4) % 64;
        if (ALIGN && (a % 4 != 0)) begin
            rd = 32'h0;
            flt = 1'b1;
        end else if (w) begin
            ref_mem[k][idx] = d;
            rd = 32'h0;
            flt = 1'b0;
        end else begin
            rd = ref_mem[k][idx];
            flt = 1'b0;
        end
    endtask

    task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_flt);
        int   lat;
        bit   mis;
        int   exp_lat;
        int   nrd;
        int   nwr;
        int   got_at;
        bit   addr_ok;
        bit   busy_ok;
        logic [31:0] rd;
        logic flt;
        lat = lat_of(k);
        mis = ALIGN && (a[1:0] != 2'b00);
        exp_lat = mis ? 1 : lat + 1;
        nrd = 0; nwr = 0; got_at = -1; addr_ok = 1'b1; busy_ok = 1'b1;
        rd = 'x; flt = 1'bx;
        @(negedge clk);
        req_write[k] = w; req_addr[k] = a; req_wdata[k] = d; req_valid[k] = 1'b1;
        for (int t = 0; t < 10 && !req_ready[k]; t++) @(negedge clk);
        chk("accept_ready", 32'(req_ready[k]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0; req_write[k] = 1'($urandom);
        req_addr[k] = $urandom; req_wdata[k] = $urandom;
        for (int j = 1; j <= 20 && got_at < 0; j++) begin
            @(negedge clk);
            if (mem_read[k]) nrd++;
            if (mem_write[k]) nwr++;
            if (mem_enable[k] && (mem_addr[k] != (a >> 2) || (w && mem_write_data[k] != d)))
                addr_ok = 1'b0;
            if (!stall[k] || req_ready[k]) busy_ok = 1'b0;
            if (resp_valid[k]) begin
                got_at = j;
                rd = resp_rdata[k];
                flt = resp_fault[k];
                if (mem_enable[k]) addr_ok = 1'b0;
            end
        end
        chk($sformatf("k%0d a=%h resp_cycle", k, a), 32'(got_at), 32'(exp_lat));
        chk($sformatf("k%0d a=%h rdata", k, a), rd, exp_rd);
        chk($sformatf("k%0d a=%h fault", k, a), 32'(flt), 32'(exp_flt));
        chk($sformatf("k%0d a=%h read_cycles", k, a), 32'(nrd), (!w && !mis) ? 32'(lat) : 32'd0);
        chk($sformatf("k%0d a=%h write_cycles", k, a), 32'(nwr), (w && !mis) ? 32'(lat) : 32'd0);
        chk($sformatf("k%0d a=%h addr_data_stable", k, a), 32'(addr_ok), 32'd1);
        chk($sformatf("k%0d a=%h stall_busy", k, a), 32'(busy_ok), 32'd1);
        @(negedge clk);
        chk($sformatf("k%0d after_resp ready/valid/stall", k),
            {29'd0, req_ready[k], resp_valid[k], stall[k]}, 32'b100);
        $display("txn k=%0d w=%0d addr=%h wdata=%h rdata=%h fault=%0d cycle=%0d",
                 k, w, a, d, rd, flt, got_at);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_flt;
    } vec_t;

    vec_t        tbl [10];
    logic [31:0] m_rd;
    logic        m_flt;
    logic        r_w;
    logic [31:0] r_a;
    logic [31:0] r_d;
    int          acc_c [2];
    int          nacc;
    int          nresp;
    logic [31:0] exp_b [2];
    bit          acc;
    bit          saw_resp;

    initial begin
        tbl[0] = '{1'b1, 32'h8,  32'd200,       32'h0,         1'b0};
        tbl[1] = '{1'b0, 32'h8,  32'h0,         32'd200,       1'b0};
        tbl[2] = '{1'b1, 32'h0,  32'h55,        32'h0,         1'b0};
        tbl[3] = '{1'b0, 32'h0,  32'h0,         32'h55,        1'b0};
        tbl[4] = '{1'b1, 32'h10, 32'hDEADBEEF,  32'h0,         1'b0};
        tbl[5] = '{1'b0, 32'h10, 32'h0,         32'hDEADBEEF,  1'b0};
        tbl[6] = '{1'b1, 32'h4,  32'h1234,      32'h0,         1'b0};
        tbl[7] = '{1'b0, 32'h6,  32'h0,         ALIGN ? 32'h0 : 32'h1234, ALIGN};
        tbl[8] = '{1'b1, 32'h7,  32'h9999,      32'h0,         ALIGN};
        tbl[9] = '{1'b0, 32'h4,  32'h0,         ALIGN ? 32'h1234 : 32'h9999, 1'b0};

        for (int k = 0; k < N; k++) begin
            req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
        end
        reset = 1'b1;
        mem_init = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++)
            chk($sformatf("k%0d ready_in_reset", k), 32'(req_ready[k]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("k%0d reset_flags", k),
                {25'd0, req_ready[k], resp_valid[k], resp_fault[k], stall[k],
                 mem_enable[k], mem_read[k], mem_write[k]}, 32'b1000000);
            chk($sformatf("k%0d reset_rdata", k), resp_rdata[k], 32'h0);
            chk($sformatf("k%0d reset_mem_addr", k), mem_addr[k], 32'h0);
            chk($sformatf("k%0d reset_mem_wdata", k), mem_write_data[k], 32'h0);
        end

        // Directed table on both latencies
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 10; i++) begin
                model(k, tbl[i].w, tbl[i].a, tbl[i].d, m_rd, m_flt);
                txn(k, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd, tbl[i].exp_flt);
            end
        end

        // Back-to-back loads with req_valid held, latency 1
        exp_b[0] = ref_mem[0][0];
        exp_b[1] = ref_mem[0][1];
        acc_c[0] = -100; acc_c[1] = -100; nacc = 0; nresp = 0;
        @(negedge clk);
        req_write[0] = 1'b0; req_addr[0] = 32'h0; req_valid[0] = 1'b1;
        for (int c = 0; c < 20 && nresp < 2; c++) begin
            if (resp_valid[0]) begin
                chk($sformatf("b2b_rdata%0d", nresp), resp_rdata[0], exp_b[nresp]);
                $display("b2b resp %0d at cycle %0d rdata=%h", nresp, c, resp_rdata[0]);
                nresp++;
            end
            acc = req_valid[0] && req_ready[0];
            if (acc) begin
                if (nacc < 2) acc_c[nacc] = c;
                nacc++;
            end else if (nacc == 1) begin
                chk("b2b_ready_low", 32'(req_ready[0]), 32'd0);
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (nacc == 1) req_addr[0] = 32'h4;
                else req_valid[0] = 1'b0;
            end
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd2);
        chk("b2b_responses", 32'(nresp), 32'd2);
        chk("b2b_accept_spacing", 32'(acc_c[1] - acc_c[0]), 32'd3);

        // Reset during the second ACCESS cycle, latency 3
        @(negedge clk);
        req_write[1] = 1'b0; req_addr[1] = 32'h10; req_valid[1] = 1'b1;
        for (int t = 0; t < 10 && !req_ready[1]; t++) @(negedge clk);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid strobe_before", 32'(mem_read[1]), 32'd1);
        chk("rst_mid ready_in_reset", 32'(req_ready[1]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid strobes_after", {29'd0, mem_enable[1], mem_read[1], mem_write[1]}, 32'd0);
        chk("rst_mid ready_after", 32'(req_ready[1]), 32'd1);
        chk("rst_mid stall_after", 32'(stall[1]), 32'd0);
        saw_resp = 1'b0;
        for (int t = 0; t < 6; t++) begin
            if (resp_valid[1]) saw_resp = 1'b1;
            @(negedge clk);
        end
        chk("rst_mid no_resp", 32'(saw_resp), 32'd0);
        $display("reset mid-access done");

        // Random transactions vs reference model
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < 30; i++) begin
                r_w = 1'($urandom);
                r_a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                if ($urandom_range(0, 3) == 0) r_a[1:0] = 2'($urandom);
                r_d = $urandom;
                model(k, r_w, r_a, r_d, m_rd, m_flt);
                txn(k, r_w, r_a, r_d, m_rd, m_flt);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
